optical_flow_host: RTL and testbench

- Host-side counterpart of the optical flow HLS core: the initiator on the ap_ctrl_hs handshake and the memory responder on the core's three BRAM-style ports.
- Serves img/prev word reads with 1-cycle latency from internal frame buffers and captures flow writes into a result buffer.
- Outside side: a simple load/readback port plus a start/done command interface with a cycle counter.
- Sits between the system controller/testbench and the optical_flow_hls wrapper.

---
 rtl/optical_flow_pkg.sv | 27 ++
 rtl/of_bram_1r1w.sv | 29 ++
 rtl/optical_flow_host.sv | 235 +++++++++++++++++++++++
 tb/tb_optical_flow_host.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/optical_flow_pkg.sv
// Shared types and defaults for the optical flow host: state encoding, load-port selects,
// and a saturating counter helper.
package optical_flow_pkg;

    localparam int DW_DEF      = 32;
    localparam int IMG_AW_DEF  = 10;
    localparam int FLOW_AW_DEF = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        FIN   = 2'd3
    } host_state_e;

    typedef enum logic [1:0] {
        LD_IMG  = 2'd0,
        LD_PREV = 2'd1,
        LD_FLOW = 2'd2,
        LD_RSVD = 2'd3
    } ld_sel_e;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/of_bram_1r1w.sv
// Single-clock RAM: one write port, one read port with a registered (1-cycle) read.
// Contents are deliberately not reset.
module of_bram_1r1w
    import optical_flow_pkg::*;
#(
    parameter int AW = IMG_AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/optical_flow_host.sv
// Host side of the optical flow core: ap_ctrl_hs initiator, frame/result buffers, load port.
// Optional macro OPTICAL_FLOW_HOST_PINGPONG_EN swaps img/prev frame banks after each clean run.
//
// state | meaning
// IDLE  | waiting for cmd_start; load port open
// START | ap_start asserted until the core reports ap_ready
// RUN   | waiting for ap_done, bounded by TIMEOUT_CYCLES
// FIN   | one-cycle done_pulse, cycle_count latched
module optical_flow_host
    import optical_flow_pkg::*;
#(
    parameter int          IMG_AW         = IMG_AW_DEF,
    parameter int          FLOW_AW        = FLOW_AW_DEF,
    parameter int          DW             = DW_DEF,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd16777215
) (
    input  logic               ap_clk,
    input  logic               ap_rst,
    input  logic               cmd_start,
    output logic               busy,
    output logic               done_pulse,
    output logic               timeout,
    output logic [31:0]        cycle_count,
    input  logic [1:0]         ld_sel,
    input  logic               ld_we,
    input  logic               ld_re,
    input  logic [FLOW_AW-1:0] ld_addr,
    input  logic [DW-1:0]      ld_wdata,
    output logic [DW-1:0]      ld_rdata,
    output logic               ld_err,
    output logic               ap_start,
    input  logic               ap_done,
    input  logic               ap_ready,
    input  logic               ap_idle,
    input  logic [IMG_AW-1:0]  img_address0,
    input  logic               img_ce0,
    output logic [DW-1:0]      img_q0,
    input  logic [IMG_AW-1:0]  prev_address0,
    input  logic               prev_ce0,
    output logic [DW-1:0]      prev_q0,
    input  logic [FLOW_AW-1:0] flow_address0,
    input  logic               flow_ce0,
    input  logic               flow_we0,
    input  logic [DW-1:0]      flow_d0
);

    host_state_e state, state_nxt;
    logic [31:0] cnt, cnt_inc;
    logic        abort;
    logic        unused_idle;

    assign unused_idle = ap_idle;
    assign cnt_inc     = sat_inc32(cnt);
    // ap_done in the same cycle as the limit still counts as a clean finish
    assign abort       = (state == RUN) && !ap_done && (cnt_inc >= TIMEOUT_CYCLES);

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        ap_start   = 1'b0;
        busy       = 1'b1;
        done_pulse = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (cmd_start) begin
                    state_nxt = START;
                end
            end
            START: begin
                ap_start = 1'b1;
                if (ap_ready) begin
                    state_nxt = ap_done ? FIN : RUN;
                end
            end
            RUN: begin
                if (ap_done || abort) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                done_pulse = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            cnt         <= '0;
            cycle_count <= '0;
            timeout     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_start) begin
                        cnt     <= '0;
                        timeout <= 1'b0;
                    end
                end
                START, RUN: begin
                    cnt <= cnt_inc;
                    if (abort) begin
                        timeout <= 1'b1;
                    end
                end
                FIN: cycle_count <= cnt;
                default: ;
            endcase
        end
    end

    // Frame bank mapping: img uses bank[bank_sel], prev uses the other bank
`ifdef OPTICAL_FLOW_HOST_PINGPONG_EN
    logic bank_sel;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            bank_sel <= 1'b0;
        end else if ((state == FIN) && !timeout) begin
            bank_sel <= ~bank_sel;
        end
    end
`else
    logic bank_sel;

    assign bank_sel = 1'b0;
`endif

    logic ld_ok, ld_wr, ld_rd, ld_is_flow, ld_frame, ld_gnt;

    assign ld_ok      = (state == IDLE) && (ld_sel != LD_RSVD);
    assign ld_wr      = ld_ok && ld_we;
    assign ld_rd      = ld_ok && ld_re && !ld_we;
    assign ld_is_flow = (ld_sel == LD_FLOW);
    assign ld_frame   = ld_sel[0] ^ bank_sel;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            ld_err <= 1'b0;
        end else if ((ld_we || ld_re) && ((state != IDLE) || (ld_sel == LD_RSVD))) begin
            ld_err <= 1'b1;
        end
    end

    logic [DW-1:0] fr_q [2];
    logic [1:0]    fr_ld_gnt;

    for (genvar gi = 0; gi < 2; gi++) begin : g_frame
        logic              is_img, core_ce, ld_hit;
        logic [IMG_AW-1:0] core_addr;

        assign is_img    = (bank_sel == 1'(gi));
        assign core_ce   = is_img ? img_ce0 : prev_ce0;
        assign core_addr = is_img ? img_address0 : prev_address0;
        assign ld_hit    = ld_rd && !ld_is_flow && (ld_frame == 1'(gi));
        // Core reads own the read port; a colliding load read is dropped
        assign fr_ld_gnt[gi] = ld_hit && !core_ce;

        of_bram_1r1w #(.AW(IMG_AW), .DW(DW)) u_frame (
            .clk   (ap_clk),
            .we    (ld_wr && !ld_is_flow && (ld_frame == 1'(gi))),
            .waddr (ld_addr[IMG_AW-1:0]),
            .wdata (ld_wdata),
            .re    (core_ce || ld_hit),
            .raddr (core_ce ? core_addr : ld_addr[IMG_AW-1:0]),
            .rdata (fr_q[gi])
        );
    end

    logic          flow_core_wr;
    logic [DW-1:0] flow_q;

    assign flow_core_wr = flow_ce0 && flow_we0;

    of_bram_1r1w #(.AW(FLOW_AW), .DW(DW)) u_flow (
        .clk   (ap_clk),
        .we    (flow_core_wr || (ld_wr && ld_is_flow)),
        .waddr (flow_core_wr ? flow_address0 : ld_addr),
        .wdata (flow_core_wr ? flow_d0 : ld_wdata),
        .re    (ld_rd && ld_is_flow),
        .raddr (ld_addr),
        .rdata (flow_q)
    );

    assign ld_gnt = (ld_rd && ld_is_flow) || (|fr_ld_gnt);

    // RAM outputs are shared, so each consumer keeps its own copy to hold between reads
    logic          img_v, prev_v, ld_v, img_bank, prev_bank;
    logic [1:0]    ld_src;
    logic [DW-1:0] img_hold, prev_hold, ld_hold;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            img_v     <= 1'b0;
            prev_v    <= 1'b0;
            ld_v      <= 1'b0;
            img_bank  <= 1'b0;
            prev_bank <= 1'b1;
            ld_src    <= 2'd0;
            img_hold  <= '0;
            prev_hold <= '0;
            ld_hold   <= '0;
        end else begin
            img_v     <= img_ce0;
            prev_v    <= prev_ce0;
            ld_v      <= ld_gnt;
            img_bank  <= bank_sel;
            prev_bank <= ~bank_sel;
            ld_src    <= ld_is_flow ? 2'd2 : {1'b0, ld_frame};
            if (img_v) begin
                img_hold <= img_q0;
            end
            if (prev_v) begin
                prev_hold <= prev_q0;
            end
            if (ld_v) begin
                ld_hold <= ld_rdata;
            end
        end
    end

    assign img_q0   = img_v  ? fr_q[img_bank]  : img_hold;
    assign prev_q0  = prev_v ? fr_q[prev_bank] : prev_hold;
    assign ld_rdata = ld_v ? ((ld_src == 2'd2) ? flow_q : fr_q[ld_src[0]]) : ld_hold;

endmodule

// File: tb/tb_optical_flow_host.sv
// Bench for optical_flow_host: behavioural buffer/bank model, randomized load and core traffic.
// Also builds with OPTICAL_FLOW_HOST_PINGPONG_EN defined (model tracks the bank swap).
module tb_optical_flow_host;
    import optical_flow_pkg::*;

    localparam logic [31:0] TO = 32'd50;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        cmd_start;
    logic        busy, done_pulse, timeout, ld_err, ap_start;
    logic [31:0] cycle_count;
    logic [1:0]  ld_sel;
    logic        ld_we, ld_re;
    logic [10:0] ld_addr;
    logic [31:0] ld_wdata, ld_rdata;
    logic        ap_done, ap_ready, ap_idle;
    logic [9:0]  img_address0, prev_address0;
    logic        img_ce0, prev_ce0;
    logic [31:0] img_q0, prev_q0;
    logic [10:0] flow_address0;
    logic        flow_ce0, flow_we0;
    logic [31:0] flow_d0;

    always #5 ap_clk = ~ap_clk;

    optical_flow_host #(.TIMEOUT_CYCLES(TO)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .cmd_start(cmd_start), .busy(busy),
        .done_pulse(done_pulse), .timeout(timeout), .cycle_count(cycle_count),
        .ld_sel(ld_sel), .ld_we(ld_we), .ld_re(ld_re), .ld_addr(ld_addr),
        .ld_wdata(ld_wdata), .ld_rdata(ld_rdata), .ld_err(ld_err), .ap_start(ap_start),
        .ap_done(ap_done), .ap_ready(ap_ready), .ap_idle(ap_idle),
        .img_address0(img_address0), .img_ce0(img_ce0), .img_q0(img_q0),
        .prev_address0(prev_address0), .prev_ce0(prev_ce0), .prev_q0(prev_q0),
        .flow_address0(flow_address0), .flow_ce0(flow_ce0), .flow_we0(flow_we0),
        .flow_d0(flow_d0)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] fr_m [2][1024];
    logic [31:0] flow_m [2048];
    logic        bsel_m;
    logic [31:0] exp_ld, exp_img, exp_prev;
    logic        exp_err;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic ld_op(input logic [1:0] sel, input logic we, input logic re,
                         input logic [10:0] addr, input logic [31:0] wd);
        @(posedge ap_clk); #1;
        ld_sel = sel; ld_we = we; ld_re = re; ld_addr = addr; ld_wdata = wd;
        @(posedge ap_clk); #1;
        ld_we = 1'b0; ld_re = 1'b0;
        if (sel == 2'd3) begin
            if (we || re) exp_err = 1'b1;
        end else if (we) begin
            if (sel == 2'd2) flow_m[addr] = wd;
            else fr_m[sel[0] ^ bsel_m][addr[9:0]] = wd;
        end else if (re) begin
            exp_ld = (sel == 2'd2) ? flow_m[addr] : fr_m[sel[0] ^ bsel_m][addr[9:0]];
        end
        @(negedge ap_clk);
        check_eq("ld_rdata", ld_rdata, exp_ld);
        check_eq("ld_err", 32'(ld_err), 32'(exp_err));
    endtask

    // Core model: ready at ap_start cycle rdy_k, done at cycle done_k (0 = never),
    // an illegal load write at cycle err_k (0 = none); reads/writes sprinkled throughout.
    task automatic do_run(input int rdy_k, input int done_k, input int err_k);
        int          starts, pulses, exp_cnt;
        logic        exp_to, pend_i, pend_p, seen;
        logic [31:0] pv_i, pv_p, fd;
        logic [9:0]  a;
        logic [10:0] fa;
        exp_to  = (done_k == 0) || (done_k > int'(TO));
        exp_cnt = exp_to ? int'(TO) : done_k;
        starts = 0; pulses = 0; pend_i = 1'b0; pend_p = 1'b0; seen = 1'b0;
        pv_i = '0; pv_p = '0;
        @(posedge ap_clk); #1; cmd_start = 1'b1;
        @(posedge ap_clk); #1; cmd_start = 1'b0;
        for (int k = 1; k <= 400 && !seen; k++) begin
            if (pend_i) exp_img = pv_i;
            if (pend_p) exp_prev = pv_p;
            ap_ready  = (k == rdy_k);
            ap_done   = (k == done_k);
            cmd_start = (k == rdy_k + 1) && ((done_k == 0) || (k < done_k));
            ld_sel = 2'd0; ld_addr = 11'd5; ld_wdata = 32'hBAD0_BAD0;
            ld_we  = (k == err_k);
            if (k == err_k) exp_err = 1'b1;
            pend_i = (k % 4 != 2);
            a = (k == 1) ? 10'd5 : 10'($urandom_range(0, 15));
            img_ce0 = pend_i; img_address0 = a; pv_i = fr_m[bsel_m][a];
            pend_p = (k % 5 != 4);
            a = 10'($urandom_range(0, 15));
            prev_ce0 = pend_p; prev_address0 = a; pv_p = fr_m[!bsel_m][a];
            flow_ce0 = 1'b0; flow_we0 = 1'b0;
            fa = 11'($urandom_range(0, 15)); fd = $urandom;
            if (k % 11 == 6) begin
                if (k == 6) begin fa = 11'd2047; fd = 32'h0000_DEAD; end
                flow_ce0 = 1'b1; flow_we0 = 1'b1; flow_m[fa] = fd;
            end else if (k % 11 == 8) begin
                flow_ce0 = 1'b1;
            end
            flow_address0 = fa; flow_d0 = fd;
            @(negedge ap_clk);
            if (ap_start) starts++;
            if (done_pulse) begin pulses++; seen = 1'b1; end
            check_eq("img_q0", img_q0, exp_img);
            check_eq("prev_q0", prev_q0, exp_prev);
            @(posedge ap_clk); #1;
        end
        cmd_start = 1'b0; ap_ready = 1'b0; ap_done = 1'b0; ld_we = 1'b0;
        img_ce0 = 1'b0; prev_ce0 = 1'b0; flow_ce0 = 1'b0; flow_we0 = 1'b0;
        if (pend_i) exp_img = pv_i;
        if (pend_p) exp_prev = pv_p;
        @(negedge ap_clk);
        check_eq("run_finished", 32'(seen), 32'd1);
        check_eq("ap_start_cycles", 32'(starts), 32'(rdy_k));
        check_eq("done_pulses", 32'(pulses), 32'd1);
        check_eq("done_pulse_width", 32'(done_pulse), 32'd0);
        check_eq("cycle_count", cycle_count, 32'(exp_cnt));
        check_eq("timeout", 32'(timeout), 32'(exp_to));
        check_eq("busy_after", 32'(busy), 32'd0);
        check_eq("img_q0_hold", img_q0, exp_img);
        check_eq("prev_q0_hold", prev_q0, exp_prev);
        check_eq("ld_err_run", 32'(ld_err), 32'(exp_err));
`ifdef OPTICAL_FLOW_HOST_PINGPONG_EN
        if (!exp_to) bsel_m = !bsel_m;
`endif
    endtask

    initial begin
        logic [1:0]  sel;
        int          op;
        logic [10:0] addr;
        ap_rst = 1'b1; cmd_start = 1'b0; ld_sel = 2'd0; ld_we = 1'b0; ld_re = 1'b0;
        ld_addr = '0; ld_wdata = '0; ap_done = 1'b0; ap_ready = 1'b0; ap_idle = 1'b1;
        img_address0 = '0; img_ce0 = 1'b0; prev_address0 = '0; prev_ce0 = 1'b0;
        flow_address0 = '0; flow_ce0 = 1'b0; flow_we0 = 1'b0; flow_d0 = '0;
        exp_ld = '0; exp_img = '0; exp_prev = '0; exp_err = 1'b0; bsel_m = 1'b0;
        repeat (3) @(posedge ap_clk);
        #1 ap_rst = 1'b0;
        @(negedge ap_clk);
        check_eq("rst_ap_start", 32'(ap_start), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done_pulse", 32'(done_pulse), 32'd0);
        check_eq("rst_timeout", 32'(timeout), 32'd0);
        check_eq("rst_cycle_count", cycle_count, 32'd0);
        check_eq("rst_ld_rdata", ld_rdata, 32'd0);
        check_eq("rst_ld_err", 32'(ld_err), 32'd0);
        check_eq("rst_img_q0", img_q0, 32'd0);
        check_eq("rst_prev_q0", prev_q0, 32'd0);

        for (int i = 0; i < 16; i++) begin
            ld_op(2'd0, 1'b1, 1'b0, 11'(i), $urandom);
            ld_op(2'd1, 1'b1, 1'b0, 11'(i), $urandom);
            ld_op(2'd2, 1'b1, 1'b0, 11'(i), $urandom);
        end
        ld_op(2'd2, 1'b1, 1'b0, 11'd2047, $urandom);
        ld_op(2'd0, 1'b1, 1'b0, 11'd5, 32'h11);
        ld_op(2'd1, 1'b1, 1'b0, 11'd5, 32'h22);
        ld_op(2'd1, 1'b0, 1'b1, 11'd5, 32'h0);
        check_eq("prev5_direct", ld_rdata, 32'h22);
        ld_op(2'd0, 1'b0, 1'b1, 11'h405, 32'h0);

        do_run(4, 101, 0);
        ld_op(2'd2, 1'b0, 1'b1, 11'd2047, 32'h0);
        check_eq("flow2047_direct", ld_rdata, 32'h0000_DEAD);
        do_run(1, 1, 0);
        ld_op(2'd0, 1'b1, 1'b0, 11'd0, 32'hA);
        do_run(2, 10, 0);
        ld_op(2'd1, 1'b0, 1'b1, 11'd0, 32'h0);
        do_run(2, 0, 10);
        ld_op(2'd0, 1'b0, 1'b1, 11'd5, 32'h0);
        ld_op(2'd1, 1'b0, 1'b1, 11'd0, 32'h0);
        do_run(3, 20, 0);

        for (int i = 0; i < 120; i++) begin
            sel = 2'($urandom_range(0, 3));
            op  = int'($urandom_range(0, 2));
            if (sel == 2'd2) addr = 11'($urandom_range(0, 15));
            else addr = 11'(($urandom_range(0, 1) << 10) | $urandom_range(0, 15));
            ld_op(sel, op != 1, op != 0, addr, $urandom);
        end

        @(posedge ap_clk); #1; cmd_start = 1'b1;
        @(posedge ap_clk); #1; cmd_start = 1'b0;
        repeat (3) @(posedge ap_clk);
        @(negedge ap_clk);
        check_eq("start_before_rst", 32'(ap_start), 32'd1);
        @(posedge ap_clk); #1; ap_rst = 1'b1;
        @(posedge ap_clk); #1; ap_rst = 1'b0;
        exp_ld = '0; exp_img = '0; exp_prev = '0; exp_err = 1'b0; bsel_m = 1'b0;
        @(negedge ap_clk);
        check_eq("midrst_ap_start", 32'(ap_start), 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_ld_err", 32'(ld_err), 32'd0);
        check_eq("midrst_cycle_count", cycle_count, 32'd0);
        check_eq("midrst_ld_rdata", ld_rdata, 32'd0);
        check_eq("midrst_img_q0", img_q0, 32'd0);
        ld_op(2'd1, 1'b0, 1'b1, 11'd5, 32'h0);
        ld_op(2'd2, 1'b0, 1'b1, 11'd2047, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
